// File: rtl/tea_tx_byte_sequencer.sv
// Purpose: serialises a 64-bit cipher block into 8 UART byte slots of FRAME_CYCLES clocks each.
// Latency: byte k starts at A+1+k*FRAME_CYCLES after acceptance at A; done pulses at A+8*FRAME_CYCLES+1.
// Backpressure: in_ready is high only in IDLE; offers made while busy are ignored, not queued.
module tea_tx_byte_sequencer #(
  parameter int FRAME_CYCLES = 11,
  parameter bit MSB_FIRST    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [63:0] in_block,
  output logic        in_ready,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        busy,
  output logic        done
);

  // A slot shorter than one UART frame (start + 8 data + stop + margin) would overrun the transmitter.
  generate
    if (FRAME_CYCLES < 11 || FRAME_CYCLES > 255) begin : g_bad_frame_cycles
      $error("tea_tx_byte_sequencer: FRAME_CYCLES must be within 11..255");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(FRAME_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [63:0] shreg;
  logic [2:0]  idx;
  logic [7:0]  cnt;
  logic        done_q;
  logic        accept;
  logic        slot_end;
  logic        last_byte;
  logic [63:0] shreg_shifted;

  assign accept        = in_valid && (state == IDLE);
  assign slot_end      = (state == WAIT) && (cnt == LAST_CNT);
  assign last_byte     = (idx == 3'd7);
  assign shreg_shifted = MSB_FIRST ? {shreg[55:0], 8'h00} : {8'h00, shreg[63:8]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: one SEND cycle per byte, then WAIT out the rest of the slot.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SEND;
      SEND: state_nxt = WAIT;
      WAIT: if (slot_end) state_nxt = last_byte ? IDLE : SEND;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state.
  always_comb begin
    in_ready   = (state == IDLE);
    busy       = (state != IDLE);
    byte_valid = (state == SEND);
  end

  // Datapath: block latch, byte shifting, slot counting and the registered done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= 64'h0;
      idx    <= 3'd0;
      cnt    <= 8'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= in_block;
            idx   <= 3'd0;
          end
        end
        SEND: cnt <= 8'd1;
        WAIT: begin
          if (slot_end) begin
            if (last_byte) begin
              // Register left unshifted so byte_data keeps the final byte while idle.
              done_q <= 1'b1;
            end else begin
              shreg <= shreg_shifted;
              idx   <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign byte_data = MSB_FIRST ? shreg[63:56] : shreg[7:0];
  assign done      = done_q;

endmodule
